// File: rtl/atributos_pkg.sv
// atributos_pkg: state codes from the main FSM and channel indices,
// shared by the attribute engine, the main FSM and the HUD.
package atributos_pkg;

  // One-hot codes driven by the main state machine on `estado`.
  localparam int         ESTADO_W   = 5;
  localparam logic [4:0] INTRO      = 5'b00000;
  localparam logic [4:0] IDLE       = 5'b00001;
  localparam logic [4:0] DORMINDO   = 5'b00010;
  localparam logic [4:0] COMENDO    = 5'b00100;
  localparam logic [4:0] DANDO_AULA = 5'b01000;
  localparam logic [4:0] MORTO      = 5'b10000;

  // Fixed meaning of the first three attribute channels.
  localparam int CH_FOME       = 0;
  localparam int CH_SONO       = 1;
  localparam int CH_FELICIDADE = 2;

  // INTRO and MORTO both mean "start a fresh pet": reload everything.
  function automatic logic eh_recarga(input logic [4:0] e);
    return (e == INTRO) || (e == MORTO);
  endfunction

endpackage

// File: rtl/gerenciador_atributos_canal.sv
// canal_atributo: one saturating attribute register. On `atualiza` it
// reloads its init value, climbs by VEL_SUBIDA or decays by VEL_DESCIDA,
// clamping to [0, MAX_VAL]. The value it is about to take is exported so the
// parent can judge death on post-update values in the same edge.
module canal_atributo #(
  parameter int                 LARGURA     = 8,
  parameter int                 MAX_VAL     = 100,
  parameter int                 VEL_DESCIDA = 1,
  parameter int                 VEL_SUBIDA  = 3,
  parameter logic [LARGURA-1:0] INIT_VAL    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               atualiza,
  input  logic               sobe,
  input  logic               recarrega,
  output logic [LARGURA-1:0] o_valor,
  output logic [LARGURA-1:0] o_proximo
);

  // One extra bit of headroom so v+VEL_SUBIDA cannot wrap before clamping.
  localparam logic [LARGURA:0] W_TETO    = (LARGURA+1)'(MAX_VAL);
  localparam logic [LARGURA:0] W_SUBIDA  = (LARGURA+1)'(VEL_SUBIDA);
  localparam logic [LARGURA:0] W_DESCIDA = (LARGURA+1)'(VEL_DESCIDA);

  logic [LARGURA-1:0] r_valor;
  logic [LARGURA:0]   w_estendido;
  logic [LARGURA:0]   w_soma;
  logic [LARGURA:0]   w_diferenca;
  logic [LARGURA-1:0] w_subido;
  logic [LARGURA-1:0] w_descido;
  logic [LARGURA-1:0] w_proximo;

  // Candidate next value: reload wins, then climb, otherwise decay.
  always_comb begin
    w_estendido = {1'b0, r_valor};
    w_soma      = w_estendido + W_SUBIDA;
    w_diferenca = w_estendido - W_DESCIDA;
    w_subido    = (w_soma > W_TETO) ? W_TETO[LARGURA-1:0] : w_soma[LARGURA-1:0];
    w_descido   = (w_estendido < W_DESCIDA) ? '0 : w_diferenca[LARGURA-1:0];
    if (recarrega) begin
      w_proximo = INIT_VAL;
    end else if (sobe) begin
      w_proximo = w_subido;
    end else begin
      w_proximo = w_descido;
    end
  end

  // Value register, only moves on update edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valor <= INIT_VAL;
    end else if (atualiza) begin
      r_valor <= w_proximo;
    end
  end

  assign o_valor   = r_valor;
  assign o_proximo = w_proximo;

endmodule

// File: rtl/gerenciador_atributos.sv
// gerenciador_atributos: attribute engine for the pet core. A prescaler
// produces the update tick; each tick every channel climbs or decays
// according to `estado`, and a death counter watches for channels stuck at 0.
module gerenciador_atributos
  import atributos_pkg::*;
#(
  parameter int                         N_ATRIB        = 3,
  parameter int                         LARGURA        = 8,
  parameter int                         MAX_VAL        = 100,
  parameter logic [N_ATRIB*LARGURA-1:0] INIT_VALS      = {8'd50, 8'd70, 8'd80},
  parameter int                         PERIODO_TICK   = 2**23,
  parameter int                         VEL_DESCIDA    = 1,
  parameter int                         VEL_SUBIDA     = 3,
  parameter int                         LIMIAR_CRITICO = 20,
  parameter int                         TICKS_MORTE    = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ESTADO_W-1:0]          estado,
  input  logic                         pausa,
  output logic [N_ATRIB*LARGURA-1:0]   atributos,
  output logic [N_ATRIB-1:0]           critico,
  output logic                         tick,
  output logic                         morte
);

  localparam int                 W_PRESC   = $clog2(PERIODO_TICK);
  localparam int                 W_CONT    = $clog2(TICKS_MORTE + 1);
  localparam logic [W_PRESC-1:0] PRESC_MAX = W_PRESC'(PERIODO_TICK - 1);
  localparam logic [W_CONT-1:0]  CONT_MAX  = W_CONT'(TICKS_MORTE);
  localparam logic [LARGURA-1:0] W_LIMIAR  = LARGURA'(LIMIAR_CRITICO);

  logic [W_PRESC-1:0]         r_presc;
  logic                       r_tick;
  logic                       r_morte;
  logic [W_CONT-1:0]          r_contMorte;
  logic                       w_update;
  logic                       w_recarga;
  logic [N_ATRIB-1:0]         w_sobe;
  logic [N_ATRIB*LARGURA-1:0] w_proximo;
  logic                       w_algumZero;
  logic [W_CONT-1:0]          w_contProx;

  // A pause on the would-be update edge leaves the prescaler parked at its
  // last count, so the update lands on the first edge after pausa drops.
  assign w_update  = (r_presc == PRESC_MAX) && !pausa;
  assign w_recarga = eh_recarga(estado);

  // Prescaler: free-running modulo PERIODO_TICK, frozen while paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (!pausa) begin
      r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + W_PRESC'(1);
    end
  end

  // Tick pulse coincides with the cycle the new values are visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_update;
    end
  end

  // Which single channel climbs; unknown or multi-hot codes make all decay.
  always_comb begin
    w_sobe = '0;
    case (estado)
      DORMINDO:   w_sobe[CH_SONO]       = 1'b1;
      COMENDO:    w_sobe[CH_FOME]       = 1'b1;
      DANDO_AULA: w_sobe[CH_FELICIDADE] = 1'b1;
      default:    w_sobe                = '0;
    endcase
  end

  for (genvar g = 0; g < N_ATRIB; g++) begin : g_canal
    canal_atributo #(
      .LARGURA     (LARGURA),
      .MAX_VAL     (MAX_VAL),
      .VEL_DESCIDA (VEL_DESCIDA),
      .VEL_SUBIDA  (VEL_SUBIDA),
      .INIT_VAL    (INIT_VALS[g*LARGURA +: LARGURA])
    ) u_canal (
      .clk       (clk),
      .rst       (rst),
      .atualiza  (w_update),
      .sobe      (w_sobe[g]),
      .recarrega (w_recarga),
      .o_valor   (atributos[g*LARGURA +: LARGURA]),
      .o_proximo (w_proximo[g*LARGURA +: LARGURA])
    );

    assign critico[g] = (atributos[g*LARGURA +: LARGURA] <= W_LIMIAR);
  end

  // Death is judged on the values the channels are about to take.
  always_comb begin
    w_algumZero = 1'b0;
    for (int i = 0; i < N_ATRIB; i++) begin
      if (w_proximo[i*LARGURA +: LARGURA] == '0) begin
        w_algumZero = 1'b1;
      end
    end
    if (w_algumZero) begin
      w_contProx = (r_contMorte == CONT_MAX) ? r_contMorte : r_contMorte + W_CONT'(1);
    end else begin
      w_contProx = '0;
    end
  end

  // Death counter and sticky death flag; only a reload edge or reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_contMorte <= '0;
      r_morte     <= 1'b0;
    end else if (w_update) begin
      if (w_recarga) begin
        r_contMorte <= '0;
        r_morte     <= 1'b0;
      end else begin
        r_contMorte <= w_contProx;
        if (w_contProx == CONT_MAX) begin
          r_morte <= 1'b1;
        end
      end
    end
  end

  assign tick  = r_tick;
  assign morte = r_morte;

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Self-checking bench for gerenciador_atributos. Three instances share the
// stimulus but differ in INIT_VALS; a small reference model fills a scoreboard
// that is drained each time the selected instance pulses tick.
module tb_gerenciador_atributos;
  import atributos_pkg::*;

  localparam int P  = 4;
  localparam int TM = 3;

  typedef struct {
    logic [23:0] atr;
    logic [2:0]  crit;
    logic        morte;
  } exp_t;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic [4:0]  estado = INTRO;
  logic        pausa  = 1'b0;
  logic [23:0] atr_o   [3];
  logic [2:0]  crit_o  [3];
  logic        tick_o  [3];
  logic        morte_o [3];

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Per instance init values, channel 0 first.
  int init_v [3][3] = '{'{80, 70, 50}, '{98, 70, 50}, '{80, 70, 2}};
  int mv     [3][3];
  int mcnt   [3];
  bit mmorte [3];

  gerenciador_atributos #(.PERIODO_TICK(P), .TICKS_MORTE(TM),
    .INIT_VALS({8'd50, 8'd70, 8'd80})) u_a (
    .clk(clk), .rst(rst), .estado(estado), .pausa(pausa),
    .atributos(atr_o[0]), .critico(crit_o[0]), .tick(tick_o[0]), .morte(morte_o[0]));

  gerenciador_atributos #(.PERIODO_TICK(P), .TICKS_MORTE(TM),
    .INIT_VALS({8'd50, 8'd70, 8'd98})) u_b (
    .clk(clk), .rst(rst), .estado(estado), .pausa(pausa),
    .atributos(atr_o[1]), .critico(crit_o[1]), .tick(tick_o[1]), .morte(morte_o[1]));

  gerenciador_atributos #(.PERIODO_TICK(P), .TICKS_MORTE(TM),
    .INIT_VALS({8'd2, 8'd70, 8'd80})) u_c (
    .clk(clk), .rst(rst), .estado(estado), .pausa(pausa),
    .atributos(atr_o[2]), .critico(crit_o[2]), .tick(tick_o[2]), .morte(morte_o[2]));

  // 10 ns clock, posedge active; the bench samples on negedge.
  always #5 clk = ~clk;

  function automatic void model_reset(input int k);
    for (int c = 0; c < 3; c++) mv[k][c] = init_v[k][c];
    mcnt[k]   = 0;
    mmorte[k] = 1'b0;
  endfunction

  function automatic void model_step(input int k, input logic [4:0] e);
    bit up;
    bit zero;
    if (e == INTRO || e == MORTO) begin
      model_reset(k);
    end else begin
      zero = 1'b0;
      for (int c = 0; c < 3; c++) begin
        up = (e == DORMINDO && c == 1) || (e == COMENDO && c == 0) || (e == DANDO_AULA && c == 2);
        if (up) mv[k][c] = (mv[k][c] + 3 > 100) ? 100 : mv[k][c] + 3;
        else    mv[k][c] = (mv[k][c] < 1) ? 0 : mv[k][c] - 1;
        if (mv[k][c] == 0) zero = 1'b1;
      end
      if (zero) mcnt[k] = (mcnt[k] == TM) ? TM : mcnt[k] + 1;
      else      mcnt[k] = 0;
      if (mcnt[k] == TM) mmorte[k] = 1'b1;
    end
  endfunction

  function automatic exp_t model_exp(input int k);
    exp_t x;
    x.atr   = {8'(mv[k][2]), 8'(mv[k][1]), 8'(mv[k][0])};
    x.crit  = {mv[k][2] <= 20, mv[k][1] <= 20, mv[k][0] <= 20};
    x.morte = mmorte[k];
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_tick(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (tick_o[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t x;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      model_reset(k);
      x = model_exp(k);
      checks++;
      if (atr_o[k] !== x.atr) begin
        errors++;
        $display("[TB] FAIL reset_atr inst %0d: got %h expected %h", k, atr_o[k], x.atr);
      end
      checks++;
      if (crit_o[k] !== x.crit || morte_o[k] !== 1'b0 || tick_o[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_flags inst %0d: got crit=%b morte=%b tick=%b expected crit=%b morte=0 tick=0",
                 k, crit_o[k], morte_o[k], tick_o[k], x.crit);
      end
    end
    estado = INTRO;
    rst    = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      checks++;
      if (tick_o[0] !== ((n % P) == 0)) begin
        errors++;
        $display("[TB] FAIL reset_tick_cycle %0d: got %b expected %b", n, tick_o[0], (n % P) == 0);
      end
    end
  endtask

  task automatic test_idle();
    exp_t x;
    bit   ok;
    estado = IDLE;
    do_reset();
    model_reset(0);
    for (int i = 0; i < 5; i++) begin
      model_step(0, IDLE);
      sb.push_back(model_exp(0));
    end
    for (int i = 0; i < 5; i++) begin
      wait_tick(0, ok);
      x = sb.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL idle_timeout %0d: got no tick expected tick within %0d cycles", i, 3 * P);
      end
      checks++;
      if (atr_o[0] !== x.atr || crit_o[0] !== x.crit || morte_o[0] !== x.morte) begin
        errors++;
        $display("[TB] FAIL idle_valores %0d: got %h/%b/%b expected %h/%b/%b",
                 i, atr_o[0], crit_o[0], morte_o[0], x.atr, x.crit, x.morte);
      end
      @(negedge clk);
      checks++;
      if (tick_o[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_tick_largura %0d: got %b expected 0", i, tick_o[0]);
      end
    end
  endtask

  task automatic test_comendo();
    exp_t x;
    bit   ok;
    estado = COMENDO;
    do_reset();
    model_reset(1);
    for (int i = 0; i < 3; i++) begin
      model_step(1, COMENDO);
      sb.push_back(model_exp(1));
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick(1, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || atr_o[1] !== x.atr || crit_o[1] !== x.crit) begin
        errors++;
        $display("[TB] FAIL comendo_sat %0d: got ok=%b %h/%b expected %h/%b",
                 i, ok, atr_o[1], crit_o[1], x.atr, x.crit);
      end
    end
  endtask

  task automatic test_morte();
    exp_t       x;
    bit         ok;
    logic [4:0] seq [7];
    seq = '{IDLE, IDLE, IDLE, IDLE, IDLE, MORTO, IDLE};
    estado = seq[0];
    do_reset();
    model_reset(2);
    for (int i = 0; i < 7; i++) begin
      model_step(2, seq[i]);
      sb.push_back(model_exp(2));
    end
    for (int i = 0; i < 7; i++) begin
      wait_tick(2, ok);
      if (i < 6) estado = seq[i + 1];
      x = sb.pop_front();
      checks++;
      if (!ok || atr_o[2] !== x.atr || crit_o[2] !== x.crit) begin
        errors++;
        $display("[TB] FAIL morte_valores %0d: got ok=%b %h/%b expected %h/%b",
                 i, ok, atr_o[2], crit_o[2], x.atr, x.crit);
      end
      checks++;
      if (morte_o[2] !== x.morte) begin
        errors++;
        $display("[TB] FAIL morte_flag %0d: got %b expected %b", i, morte_o[2], x.morte);
      end
    end
  endtask

  task automatic test_pausa();
    exp_t x;
    exp_t x0;
    estado = IDLE;
    do_reset();
    model_reset(0);
    x0 = model_exp(0);
    repeat (P - 1) @(negedge clk);
    pausa = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (tick_o[0] !== 1'b0 || atr_o[0] !== x0.atr) begin
        errors++;
        $display("[TB] FAIL pausa_congelado %0d: got tick=%b %h expected tick=0 %h",
                 i, tick_o[0], atr_o[0], x0.atr);
      end
    end
    pausa = 1'b0;
    model_step(0, IDLE);
    sb.push_back(model_exp(0));
    @(negedge clk);
    x = sb.pop_front();
    checks++;
    if (tick_o[0] !== 1'b1 || atr_o[0] !== x.atr) begin
      errors++;
      $display("[TB] FAIL pausa_retoma: got tick=%b %h expected tick=1 %h", tick_o[0], atr_o[0], x.atr);
    end
  endtask

  task automatic test_troca_estados();
    exp_t       x;
    bit         ok;
    logic [4:0] seq [7];
    seq = '{DORMINDO, DORMINDO, DANDO_AULA, DANDO_AULA, 5'b00110, COMENDO, INTRO};
    estado = seq[0];
    do_reset();
    model_reset(0);
    for (int i = 0; i < 7; i++) begin
      model_step(0, seq[i]);
      sb.push_back(model_exp(0));
    end
    for (int i = 0; i < 7; i++) begin
      wait_tick(0, ok);
      if (i < 6) estado = seq[i + 1];
      x = sb.pop_front();
      checks++;
      if (!ok || atr_o[0] !== x.atr) begin
        errors++;
        $display("[TB] FAIL troca_estados %0d: got ok=%b %h expected %h", i, ok, atr_o[0], x.atr);
      end
    end
  endtask

  task automatic test_reset_assincrono();
    exp_t x;
    exp_t x0;
    bit   ok;
    estado = IDLE;
    do_reset();
    model_reset(2);
    for (int i = 0; i < 5; i++) begin
      model_step(2, IDLE);
      sb.push_back(model_exp(2));
    end
    for (int i = 0; i < 5; i++) begin
      wait_tick(2, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || atr_o[2] !== x.atr || morte_o[2] !== x.morte) begin
        errors++;
        $display("[TB] FAIL rst_pre %0d: got ok=%b %h morte=%b expected %h morte=%b",
                 i, ok, atr_o[2], morte_o[2], x.atr, x.morte);
      end
    end
    model_reset(2);
    x0 = model_exp(2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (atr_o[2] !== x0.atr || crit_o[2] !== x0.crit) begin
      errors++;
      $display("[TB] FAIL rst_async_atr: got %h/%b expected %h/%b", atr_o[2], crit_o[2], x0.atr, x0.crit);
    end
    checks++;
    if (tick_o[2] !== 1'b0 || morte_o[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_async_flags: got tick=%b morte=%b expected 0 0", tick_o[2], morte_o[2]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= P; n++) begin
      @(negedge clk);
      checks++;
      if (tick_o[2] !== (n == P)) begin
        errors++;
        $display("[TB] FAIL rst_primeiro_tick cycle %0d: got %b expected %b", n, tick_o[2], n == P);
      end
    end
  endtask

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_idle();
    test_comendo();
    test_morte();
    test_pausa();
    test_troca_estados();
    test_reset_assincrono();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gerenciador_atributos.md
# gerenciador_atributos

Parametrised attribute engine for the pet core: holds N saturating attributes (channel 0 fome, 1 sono, 2 felicidade, extra channels generic). It updates them on a programmable tick according to the one-hot `estado` from the main FSM, and adds pause, critical-level flags and death detection. It sits between the main state machine (consumes `estado`, returns `morte`) and the display/HUD logic (consumes `atributos`, `critico`, `tick`).

## Interface
- `N_ATRIB`, 3: number of attribute channels (≥3).
- `LARGURA`, 8: bits per attribute.
- `MAX_VAL`, 100: saturation ceiling, < 2^LARGURA.
- `INIT_VALS`, {8'd50,8'd70,8'd80}: packed N_ATRIB×LARGURA init values. Channel 0 is the LSB slice.
- `PERIODO_TICK`, 2^23: clock cycles per tick (≥2). Prescaler width is clog2(PERIODO_TICK).
- `VEL_DESCIDA`, 1: decrement per tick.
- `VEL_SUBIDA`, 3: increment per tick.
- `LIMIAR_CRITICO`, 20: an attribute ≤ this value is critical.
- `TICKS_MORTE`, 10: consecutive ticks with any attribute at 0 before death (≥1).

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `estado` in 5: one-hot FSM state. INTRO=00000, IDLE=00001, DORMINDO=00010, COMENDO=00100, DANDO_AULA=01000, MORTO=10000.
- `pausa` in 1: freezes prescaler and all attribute/death state while high.
- `atributos` out N_ATRIB×LARGURA: packed attribute values, channel i at [i*LARGURA +: LARGURA].
- `critico` out N_ATRIB: bit i = (atributo i ≤ LIMIAR_CRITICO); combinational from registers.
- `tick` out 1: one-cycle pulse, high in the cycle new values first appear.
- `morte` out 1: death flag, level, registered.

## Operation
- Prescaler counts 0..PERIODO_TICK−1 while `pausa`=0 and holds its value while `pausa`=1.
- Update edge: the clock edge where prescaler = PERIODO_TICK−1 and `pausa`=0. On it: prescaler→0, `tick`→1, attributes update per `estado` sampled on that edge. On every other edge `tick`→0.
- Saturating up: v > MAX_VAL−VEL_SUBIDA ? MAX_VAL : v+VEL_SUBIDA.
- Saturating down: v < VEL_DESCIDA ? 0 : v−VEL_DESCIDA. No wrap in either direction.
- INTRO or MORTO: all channels reload INIT_VALS, death counter→0, `morte`→0.
- DORMINDO: ch1 up, all others down.
- COMENDO: ch0 up, all others down.
- DANDO_AULA: ch2 up, all others down.
- IDLE, or any non-listed/multi-hot code: all channels down.
- Channels ≥3 only ever decay, or reload in INTRO/MORTO.
- Death counter: evaluated on update edges outside INTRO/MORTO, using post-update values.
  - If any channel = 0, counter increments, saturating at TICKS_MORTE.
  - Otherwise the counter clears.
  - `morte` sets when the counter reaches TICKS_MORTE.
  - `morte` stays set until an update edge in INTRO/MORTO or reset. Recovery of attributes does not clear it.
- `morte` high does not stop attribute updates.

## Timing
- Reset values:
  - `atributos` = INIT_VALS.
  - Prescaler, death counter, `tick`, `morte` = 0.
  - `critico` is derived from INIT_VALS.
- First `tick`: PERIODO_TICK cycles after `rst` deasserts, with `pausa` low throughout.
- Update latency: `estado` is sampled on the update edge; new `atributos`, `tick` and `morte` are visible in the same following cycle.
- `critico` changes in the same cycle as `atributos`; no added latency.
- `pausa` asserted on the would-be update edge: the update is suppressed. It occurs on the first edge after `pausa` falls, because the prescaler is still at PERIODO_TICK−1.
- `rst` mid-period or mid-countdown: all state returns immediately (asynchronously) to reset values.

## Structure
- Package `atributos_pkg`:
  - `estado` localparams: INTRO, IDLE, DORMINDO, COMENDO, DANDO_AULA, MORTO.
  - Channel indices CH_FOME=0, CH_SONO=1, CH_FELICIDADE=2.
  - Shared by the main FSM and the HUD.
- Sub-module `canal_atributo`, instantiated N_ATRIB times via generate. It contains:
  - one LARGURA register with async reset to its INIT slice;
  - inputs `atualiza`, `sobe`, `recarrega`;
  - saturating up/down logic.
- Top level holds the prescaler, the per-channel up-select decode and the death counter (clog2(TICKS_MORTE+1) bits).

## Test plan
Bench parameters: PERIODO_TICK=4, TICKS_MORTE=3, defaults otherwise.
- Reset release: `atributos`={50,70,80}, `morte`=0, `critico`=000. `tick` pulses exactly at cycles 4, 8, 12 after release.
- IDLE, 5 ticks → ch0 80→75, ch1 70→65, ch2 50→45. `tick` is one cycle wide each time.
- COMENDO with ch0 forced to 98 via INIT_VALS → 100 after one tick, stays 100 on the next. Ch1 and ch2 decrement by 1 per tick.
- INIT_VALS ch2=2, IDLE:
  - ch2 goes 1, 0, and stays 0.
  - `critico[2]` is high throughout.
  - `morte` rises on the 3rd consecutive tick with ch2=0 and stays high.
  - Switching to MORTO: next tick reloads INIT_VALS and clears `morte`.
- `pausa` high for 10 cycles starting at prescaler=3: no `tick`, values frozen. The update occurs on the first edge after `pausa` drops.
- `rst` pulsed between clock edges mid-period after several updates: `atributos` returns to INIT_VALS and `tick`/`morte` to 0 without waiting for `clk`. The first tick comes 4 cycles after release.
